// File: rtl/console_pkg.sv
// console_pkg
// Shared definitions for the MMIO console: FSM state encoding, default
// register addresses, ASCII constants and the nibble-to-hex-digit helper.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEX,
    STR_REQ,
    STR_WAIT,
    STR_EMIT,
    NL
  } state_t;

  localparam logic [15:0] DEF_INT_ADDR    = 16'h1000;
  localparam logic [15:0] DEF_STR_ADDR    = 16'h1002;
  localparam logic [15:0] DEF_STAT_ADDR   = 16'h1004;
  localparam int          DEF_MAX_STR_LEN = 512;

  localparam logic [7:0] NEWLINE = 8'h0A;

  // Lowercase hex digit: 0-9 map to 0x30-0x39, a-f map to 0x61-0x66.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) begin
      return 8'h30 + {4'h0, i_nib};
    end
    return 8'h57 + {4'h0, i_nib};
  endfunction

endpackage

// File: rtl/console_char_reg.sv
// console_char_reg
// One-entry output holding register with a valid/ready handshake.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_load, i_data    capture a new byte (only while empty or being accepted)
//   o_char, o_valid   byte presented to the sink
//   i_ready           sink accepts o_char
//   o_accepted        a transfer happens this cycle
module console_char_reg (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_accepted
);

  logic [7:0] r_char;
  logic       r_valid;

  assign o_char     = r_char;
  assign o_valid    = r_valid;
  assign o_accepted = r_valid && i_ready;

  // A load may coincide with acceptance of the previous byte, so load wins
  // and keeps valid high for back-to-back bytes; otherwise acceptance empties.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_char  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_char  <= i_data;
      r_valid <= 1'b1;
    end else if (o_accepted) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// mmio_console
// Bus responder that turns CPU result writes into an ASCII byte stream.
// A write to INT_ADDR prints the value as four lowercase hex digits plus
// newline; a write to STR_ADDR prints the null-terminated string (one char
// per 16-bit word, low byte) stored at that byte address, fetched through
// its own read port into RAM. STAT_ADDR exposes busy/overflow/truncated.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_bus_addr/rd/wr/wrdata        CPU bus request
//   o_bus_rddata                   status read data, one cycle after i_bus_rd
//   o_mem_addr, o_mem_rd           string fetch request
//   i_mem_rddata                   fetch data, valid the cycle after o_mem_rd
//   o_char, o_char_valid, i_char_ready  character output handshake
//   o_busy                         a print job is in progress
module mmio_console
  import console_pkg::*;
#(
  parameter logic [15:0] INT_ADDR    = DEF_INT_ADDR,
  parameter logic [15:0] STR_ADDR    = DEF_STR_ADDR,
  parameter logic [15:0] STAT_ADDR   = DEF_STAT_ADDR,
  parameter int          MAX_STR_LEN = DEF_MAX_STR_LEN
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_rd,
  input  logic        i_bus_wr,
  input  logic [15:0] i_bus_wrdata,
  output logic [15:0] o_bus_rddata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_rddata,
  output logic [7:0]  o_char,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  state_t            r_state;
  logic [15:0]       r_value;
  logic [1:0]        r_digit;
  logic [15:0]       r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_mem_rd;
  logic [15:0]       r_mem_addr;
  logic              r_overflow;
  logic              r_truncated;
  logic [15:0]       r_bus_rddata;

  logic              w_int_wr;
  logic              w_str_wr;
  logic              w_stat_wr;
  logic              w_stat_rd;
  logic              w_accepted;
  logic              w_load;
  logic [7:0]        w_load_data;
  logic [3:0]        w_next_nib;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_cnt_full;

  assign w_int_wr   = i_bus_wr && (i_bus_addr == INT_ADDR);
  assign w_str_wr   = i_bus_wr && (i_bus_addr == STR_ADDR);
  assign w_stat_wr  = i_bus_wr && (i_bus_addr == STAT_ADDR);
  assign w_stat_rd  = i_bus_rd && (i_bus_addr == STAT_ADDR);
  assign w_cnt_next = r_count + 1'b1;
  assign w_cnt_full = (w_cnt_next == CNT_W'(MAX_STR_LEN));

  assign o_busy       = (r_state != IDLE);
  assign o_mem_rd     = r_mem_rd;
  assign o_mem_addr   = r_mem_addr;
  assign o_bus_rddata = r_bus_rddata;

  // r_digit names the nibble currently in the output register; the next one
  // down is the one to load when it is accepted.
  always_comb begin
    w_next_nib = r_value[15:12];
    case (r_digit)
      2'd3:    w_next_nib = r_value[11:8];
      2'd2:    w_next_nib = r_value[7:4];
      2'd1:    w_next_nib = r_value[3:0];
      default: w_next_nib = r_value[15:12];
    endcase
  end

  // Output-register load strobe. Loads happen on the same edge as the state
  // change so the first hex digit is valid the cycle after the job write and
  // emitting states never leave a bubble between accept and next byte.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_int_wr) begin
          w_load      = 1'b1;
          w_load_data = nibble_to_ascii(i_bus_wrdata[15:12]);
        end
      end
      HEX: begin
        if (w_accepted) begin
          w_load      = 1'b1;
          w_load_data = (r_digit == 2'd0) ? NEWLINE : nibble_to_ascii(w_next_nib);
        end
      end
      STR_WAIT: begin
        w_load      = 1'b1;
        w_load_data = (i_mem_rddata == 16'h0000) ? NEWLINE : i_mem_rddata[7:0];
      end
      STR_EMIT: begin
        if (w_accepted && w_cnt_full) begin
          w_load      = 1'b1;
          w_load_data = NEWLINE;
        end
      end
      default: begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
      end
    endcase
  end

  // Job FSM, fetch port and status flags. Flag clears are written before the
  // set events so that a same-cycle set overrides the write-1-to-clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_value      <= 16'h0000;
      r_digit      <= 2'd0;
      r_ptr        <= 16'h0000;
      r_count      <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_overflow   <= 1'b0;
      r_truncated  <= 1'b0;
      r_bus_rddata <= 16'h0000;
    end else begin
      r_mem_rd     <= 1'b0;
      r_bus_rddata <= w_stat_rd ? {13'h0000, r_truncated, r_overflow, o_busy} : 16'h0000;

      if (w_stat_wr && i_bus_wrdata[1]) r_overflow  <= 1'b0;
      if (w_stat_wr && i_bus_wrdata[2]) r_truncated <= 1'b0;
      if ((w_int_wr || w_str_wr) && (r_state != IDLE)) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_int_wr) begin
            r_value <= i_bus_wrdata;
            r_digit <= 2'd3;
            r_state <= HEX;
          end else if (w_str_wr) begin
            r_ptr      <= i_bus_wrdata;
            r_count    <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= i_bus_wrdata;
            r_state    <= STR_REQ;
          end
        end
        HEX: begin
          if (w_accepted) begin
            if (r_digit == 2'd0) r_state <= NL;
            else                 r_digit <= r_digit - 2'd1;
          end
        end
        STR_REQ: begin
          r_state <= STR_WAIT;
        end
        STR_WAIT: begin
          r_state <= (i_mem_rddata == 16'h0000) ? NL : STR_EMIT;
        end
        STR_EMIT: begin
          if (w_accepted) begin
            r_ptr   <= r_ptr + 16'd2;
            r_count <= w_cnt_next;
            if (w_cnt_full) begin
              r_truncated <= 1'b1;
              r_state     <= NL;
            end else begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_ptr + 16'd2;
              r_state    <= STR_REQ;
            end
          end
        end
        NL: begin
          if (w_accepted) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  console_char_reg u_char_reg (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_ready    (i_char_ready),
    .o_char     (o_char),
    .o_valid    (o_char_valid),
    .o_accepted (w_accepted)
  );

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console
// Directed bench for mmio_console with a scoreboard of expected characters
// and expected fetch addresses, a RAM model answering string fetches, and a
// ready generator that can hold, stream, or randomly stall the sink.
module tb_mmio_console;

  logic        clk;
  logic        reset;
  logic [15:0] busAddr;
  logic        busRd;
  logic        busWr;
  logic [15:0] busWrData;
  logic [15:0] busRdData;
  logic [15:0] memAddr;
  logic        memRd;
  logic [15:0] memData;
  logic [7:0]  charOut;
  logic        charValid;
  logic        charReady;
  logic        busy;

  logic [15:0] ram [0:32767];
  logic [7:0]  charQ [$];
  logic [15:0] fetchQ [$];

  int errors = 0;
  int checks = 0;
  int xferCount = 0;
  int rdCount = 0;
  int readyMode = 1;
  int base;
  logic       prevStall = 1'b0;
  logic [7:0] prevChar = 8'h00;
  logic       prevRd = 1'b0;

  mmio_console dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_bus_addr   (busAddr),
    .i_bus_rd     (busRd),
    .i_bus_wr     (busWr),
    .i_bus_wrdata (busWrData),
    .o_bus_rddata (busRdData),
    .o_mem_addr   (memAddr),
    .o_mem_rd     (memRd),
    .i_mem_rddata (memData),
    .o_char       (charOut),
    .o_char_valid (charValid),
    .i_char_ready (charReady),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic failNow(input string tag, input logic [15:0] obs);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=%h expected=none", tag, obs);
  endtask

  // One bus cycle: drive just after a rising edge, release after the next.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               input logic rd, input logic wr);
    @(posedge clk);
    #1;
    busAddr = addr; busWrData = data; busRd = rd; busWr = wr;
    @(posedge clk);
    #1;
    busRd = 1'b0; busWr = 1'b0;
  endtask

  task automatic readStatus(input string tag, input logic [15:0] exp);
    applyStimulus(16'h1004, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput(tag, busRdData, exp);
  endtask

  task automatic pushHex(input logic [15:0] v);
    logic [3:0] n;
    for (int i = 3; i >= 0; i--) begin
      n = v[i*4 +: 4];
      charQ.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10));
    end
    charQ.push_back(8'h0A);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || charQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) failNow({tag, "_timeout"}, 16'(charQ.size()));
    checkOutput({tag, "_fetchq_empty"}, 16'(fetchQ.size()), 16'd0);
  endtask

  // Sink ready: 0 = hold off, 1 = always ready, 2 = ready about 1 in 3.
  initial begin
    charReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0)      charReady = 1'b0;
      else if (readyMode == 1) charReady = 1'b1;
      else                     charReady = ($urandom_range(0, 2) == 0);
    end
  end

  // RAM model: data appears the cycle after the fetch strobe.
  initial begin
    logic [15:0] a;
    memData = 16'h0000;
    forever begin
      @(negedge clk);
      if (!reset && memRd) begin
        a = memAddr;
        @(posedge clk);
        #1;
        memData = ram[a[15:1]];
      end
    end
  end

  // Output and fetch monitor, sampled on the falling edge.
  initial begin
    logic [7:0]  expChar;
    logic [15:0] expAddr;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 1'b0;
        prevRd    = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_valid_held", {15'h0, charValid}, 16'h0001);
          checkOutput("stall_char_held", {8'h00, charOut}, {8'h00, prevChar});
        end
        if (charValid && charReady) begin
          xferCount++;
          if (charQ.size() == 0) failNow("unexpected_char", {8'h00, charOut});
          else begin
            expChar = charQ.pop_front();
            checkOutput("char", {8'h00, charOut}, {8'h00, expChar});
          end
        end
        prevStall = charValid && !charReady;
        prevChar  = charOut;
        if (memRd) begin
          rdCount++;
          checkOutput("fetch_single_pulse", {15'h0, prevRd}, 16'h0000);
          if (fetchQ.size() == 0) failNow("unexpected_fetch", memAddr);
          else begin
            expAddr = fetchQ.pop_front();
            checkOutput("fetch_addr", memAddr, expAddr);
          end
        end
        prevRd = memRd;
      end
    end
  end

  initial begin
    reset = 1'b1;
    busAddr = 16'h0000; busRd = 1'b0; busWr = 1'b0; busWrData = 16'h0000;
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid",  {15'h0, charValid}, 16'h0000);
    checkOutput("rst_mem_rd", {15'h0, memRd}, 16'h0000);
    checkOutput("rst_busy",   {15'h0, busy}, 16'h0000);
    checkOutput("rst_rddata", busRdData, 16'h0000);
    checkOutput("rst_char",   {8'h00, charOut}, 16'h0000);
    checkOutput("rst_memaddr", memAddr, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;

    // Integer print
    $display("[TB] hex print 12af");
    readyMode = 1;
    base = rdCount;
    pushHex(16'h12af);
    applyStimulus(16'h1000, 16'h12af, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("hex_first_valid", {15'h0, charValid}, 16'h0001);
    checkOutput("hex_busy", {15'h0, busy}, 16'h0001);
    waitDone("hex", 100);
    checkOutput("hex_no_fetch", 16'(rdCount - base), 16'd0);
    checkOutput("hex_idle", {15'h0, busy}, 16'h0000);

    // String print "Hi"
    $display("[TB] string print Hi");
    ram[16'h1000] = 16'h7F48;
    ram[16'h1001] = 16'h0069;
    ram[16'h1002] = 16'h0000;
    base = rdCount;
    charQ.push_back(8'h48); charQ.push_back(8'h69); charQ.push_back(8'h0A);
    fetchQ.push_back(16'h2000); fetchQ.push_back(16'h2002); fetchQ.push_back(16'h2004);
    applyStimulus(16'h1002, 16'h2000, 1'b0, 1'b1);
    waitDone("str", 200);
    checkOutput("str_fetch_count", 16'(rdCount - base), 16'd3);

    // Same string under random backpressure
    $display("[TB] string print with random stalls");
    readyMode = 2;
    charQ.push_back(8'h48); charQ.push_back(8'h69); charQ.push_back(8'h0A);
    fetchQ.push_back(16'h2000); fetchQ.push_back(16'h2002); fetchQ.push_back(16'h2004);
    applyStimulus(16'h1002, 16'h2000, 1'b0, 1'b1);
    waitDone("str_stall", 500);
    readyMode = 1;

    // Overflow on writes while busy, status reads and clears
    $display("[TB] overflow and status");
    readyMode = 0;
    pushHex(16'hbeef);
    applyStimulus(16'h1000, 16'hbeef, 1'b0, 1'b1);
    applyStimulus(16'h1000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(16'h1002, 16'h2000, 1'b0, 1'b1);
    readStatus("stat_busy_ovf", 16'h0003);
    readyMode = 1;
    waitDone("ovf_job", 100);
    readStatus("stat_ovf_idle", 16'h0002);
    applyStimulus(16'h1006, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("other_addr_read", busRdData, 16'h0000);
    applyStimulus(16'h1004, 16'h0002, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rdwr_pre_write", busRdData, 16'h0002);
    readStatus("stat_cleared", 16'h0000);

    // Truncation at 512 characters
    $display("[TB] truncation");
    for (int i = 0; i < 600; i++) ram[i] = 16'h0100 | (16'h0041 + 16'(i % 26));
    ram[600] = 16'h0000;
    base = rdCount;
    for (int i = 0; i < 512; i++) begin
      charQ.push_back(8'h41 + 8'(i % 26));
      fetchQ.push_back(16'(i * 2));
    end
    charQ.push_back(8'h0A);
    applyStimulus(16'h1002, 16'h0000, 1'b0, 1'b1);
    waitDone("trunc", 5000);
    checkOutput("trunc_fetch_count", 16'(rdCount - base), 16'd512);
    readStatus("stat_trunc", 16'h0004);
    applyStimulus(16'h1004, 16'h0004, 1'b0, 1'b1);
    readStatus("stat_trunc_cleared", 16'h0000);

    // Pointer wrap from 0xFFFE to 0x0000
    $display("[TB] pointer wrap");
    ram[0] = 16'h0000;
    ram[16'h7FFF] = 16'h0041;
    charQ.push_back(8'h41); charQ.push_back(8'h0A);
    fetchQ.push_back(16'hFFFE); fetchQ.push_back(16'h0000);
    applyStimulus(16'h1002, 16'hFFFE, 1'b0, 1'b1);
    waitDone("wrap", 200);

    // Reset in the middle of a string job
    $display("[TB] reset mid-string");
    ram[16'h1800] = 16'h0041; ram[16'h1801] = 16'h0042; ram[16'h1802] = 16'h0043;
    ram[16'h1803] = 16'h0044; ram[16'h1804] = 16'h0000;
    charQ.push_back(8'h41); charQ.push_back(8'h42);
    fetchQ.push_back(16'h3000); fetchQ.push_back(16'h3002);
    base = xferCount;
    applyStimulus(16'h1002, 16'h3000, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (xferCount - base < 2 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 200) failNow("reset_wait_timeout", 16'(xferCount - base));
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid",  {15'h0, charValid}, 16'h0000);
    checkOutput("midrst_mem_rd", {15'h0, memRd}, 16'h0000);
    checkOutput("midrst_busy",   {15'h0, busy}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("midrst_charq_empty", 16'(charQ.size()), 16'd0);
    fetchQ.delete();
    readStatus("midrst_status", 16'h0000);
    pushHex(16'h0c3d);
    applyStimulus(16'h1000, 16'h0c3d, 1'b0, 1'b1);
    waitDone("post_reset_hex", 100);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
